hazard_sequencer: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It decides each cycle whether the pipeline advances, stalls, bubbles or flushes. Inputs are ID-stage operand fields, EX-stage load information, ID-stage branch resolution and MEM-stage memory accesses. It drives the PC/IF-ID write enables, the `NoOp_i` input of the main decoder, the IF/ID flush, and a global freeze for the ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and flush performance counters.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/hazard_sequencer_detect.sv | 23 ++
 rtl/hazard_sequencer.sv | 135 +++++++++++++
 tb/tb_hazard_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes used by the decoder and the sequencer,
// plus the state encoding of the pipeline sequencing FSM.
package cpu_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_MEMWAIT = 2'd2;

   // Only R-type, store and branch instructions actually read rs2.
   function automatic logic usesRs2(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/hazard_sequencer_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load still sitting in EX.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic [6:0] idOp,
   input  logic [4:0] idRs1,
   input  logic [4:0] idRs2,
   input  logic       exMemRead,
   input  logic [4:0] exRd,
   output logic       loadUse
);

   logic rs2Used;

   // rs1 counts as read for every opcode; x0 never creates a dependency.
   always_comb begin
      rs2Used = usesRs2(idOp);
      loadUse = exMemRead && (exRd != 5'd0) &&
                ((exRd == idRs1) || (rs2Used && (exRd == idRs2)));
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: chooses advance / bubble / flush / freeze
// each cycle, tracks multi-cycle memory accesses and counts stall and flush
// cycles with saturating counters.
module hazard_sequencer #(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [6:0]       ID_Op_i,
   input  logic [4:0]       ID_rs1_i,
   input  logic [4:0]       ID_rs2_i,
   input  logic             EX_MemRead_i,
   input  logic [4:0]       EX_rd_i,
   input  logic             ID_BranchTaken_i,
   input  logic             MEM_Access_i,
   output logic             PCWrite_o,
   output logic             IFID_Write_o,
   output logic             NoOp_o,
   output logic             IFID_Flush_o,
   output logic             PipeStall_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   import cpu_pkg::*;

   localparam logic       MEM_FREEZE = (MEM_LAT > 1);
   localparam logic [3:0] WAIT_LOAD  = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

   logic [1:0] state;
   logic [1:0] stateNext;
   logic [3:0] waitCnt;
   logic [3:0] waitNext;
   logic       loadUse;
   logic       memTrig;
   logic       freeze;

   hazard_detect detect (
      .idOp      (ID_Op_i),
      .idRs1     (ID_rs1_i),
      .idRs2     (ID_rs2_i),
      .exMemRead (EX_MemRead_i),
      .exRd      (EX_rd_i),
      .loadUse   (loadUse)
   );

   // A freeze starts on the first cycle an access is in MEM and lasts until
   // the wait counter drains; the release cycle itself is not frozen.
   always_comb begin
      memTrig = (state == ST_RUN) && MEM_Access_i && MEM_FREEZE;
      freeze  = memTrig || ((state == ST_MEMWAIT) && (waitCnt != 4'd0));
   end

   // Output priority: idle, memory freeze, load-use bubble, taken branch.
   always_comb begin
      PCWrite_o    = 1'b1;
      IFID_Write_o = 1'b1;
      NoOp_o       = 1'b0;
      IFID_Flush_o = 1'b0;
      PipeStall_o  = 1'b0;
      if (state == ST_IDLE) begin
         PCWrite_o    = 1'b0;
         IFID_Write_o = 1'b0;
         NoOp_o       = 1'b1;
      end else if (freeze) begin
         PCWrite_o    = 1'b0;
         IFID_Write_o = 1'b0;
         PipeStall_o  = 1'b1;
      end else if (loadUse) begin
         PCWrite_o    = 1'b0;
         IFID_Write_o = 1'b0;
         NoOp_o       = 1'b1;
      end else if (ID_BranchTaken_i) begin
         IFID_Flush_o = 1'b1;
      end
   end

   // Next-state logic; an unused encoding falls back to IDLE.
   always_comb begin
      stateNext = state;
      waitNext  = waitCnt;
      case (state)
         ST_IDLE: begin
            if (start_i) stateNext = ST_RUN;
         end
         ST_RUN: begin
            if (memTrig) begin
               stateNext = ST_MEMWAIT;
               waitNext  = WAIT_LOAD;
            end
         end
         ST_MEMWAIT: begin
            if (waitCnt != 4'd0) begin
               waitNext = waitCnt - 4'd1;
            end else begin
               stateNext = ST_RUN;
            end
         end
         default: begin
            stateNext = ST_IDLE;
            waitNext  = 4'd0;
         end
      endcase
   end

   // State register with asynchronous clear back to IDLE.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= ST_IDLE;
         waitCnt <= 4'd0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitNext;
      end
   end

   // Saturating performance counters, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if ((state != ST_IDLE) && !PCWrite_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         if (IFID_Flush_o && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Testbench for hazard_sequencer: directed scenarios plus a randomized run,
// with two instances (wide and 3-bit counters) checked against a
// cycle-level behavioural model of the sequencing rules.
module tb_hazard_sequencer;

   localparam int LAT = 4;
   localparam int WA  = 16;
   localparam int WB  = 3;
   localparam int MAXA = (1 << WA) - 1;
   localparam int MAXB = (1 << WB) - 1;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_L   = 7'b0000011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_I   = 7'b0010011;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start;
   logic [6:0]  idOp;
   logic [4:0]  idRs1, idRs2, exRd;
   logic        exMemRead, brTaken, memAccess;

   logic        pcA, ifidA, noopA, flushA, psA;
   logic [1:0]  stateA;
   logic [WA-1:0] stallCntA, flushCntA;
   logic        pcB, ifidB, noopB, flushB, psB;
   logic [1:0]  stateB;
   logic [WB-1:0] stallCntB, flushCntB;

   int checks = 0;
   int errors = 0;

   // Model state: running flag, remaining MEMWAIT cycles of the current access.
   bit mRun;
   int mOcc;
   int mStallA, mStallB, mFlushA, mFlushB;
   bit ePc, eIfid, eNoOp, eFlush, ePs, eTrig;
   int eState;

   always #5 clk = ~clk;

   hazard_sequencer #(.MEM_LAT(LAT), .CNT_W(WA)) dutA (
      .clk_i(clk), .rst_i(rstN), .start_i(start), .ID_Op_i(idOp),
      .ID_rs1_i(idRs1), .ID_rs2_i(idRs2), .EX_MemRead_i(exMemRead),
      .EX_rd_i(exRd), .ID_BranchTaken_i(brTaken), .MEM_Access_i(memAccess),
      .PCWrite_o(pcA), .IFID_Write_o(ifidA), .NoOp_o(noopA),
      .IFID_Flush_o(flushA), .PipeStall_o(psA), .state_o(stateA),
      .stall_cnt_o(stallCntA), .flush_cnt_o(flushCntA)
   );

   hazard_sequencer #(.MEM_LAT(LAT), .CNT_W(WB)) dutB (
      .clk_i(clk), .rst_i(rstN), .start_i(start), .ID_Op_i(idOp),
      .ID_rs1_i(idRs1), .ID_rs2_i(idRs2), .EX_MemRead_i(exMemRead),
      .EX_rd_i(exRd), .ID_BranchTaken_i(brTaken), .MEM_Access_i(memAccess),
      .PCWrite_o(pcB), .IFID_Write_o(ifidB), .NoOp_o(noopB),
      .IFID_Flush_o(flushB), .PipeStall_o(psB), .state_o(stateB),
      .stall_cnt_o(stallCntB), .flush_cnt_o(flushCntB)
   );

   // Expected outputs for the current cycle from the model and the inputs.
   task automatic modelEval();
      bit r2, lu, frz;
      r2 = (idOp == OP_R) || (idOp == OP_S) || (idOp == OP_B);
      lu = exMemRead && (exRd != 0) && ((exRd == idRs1) || (r2 && (exRd == idRs2)));
      eTrig = mRun && (mOcc == 0) && memAccess && (LAT > 1);
      frz = eTrig || (mOcc > 1);
      eState = !mRun ? 0 : ((mOcc > 0) ? 2 : 1);
      if (!mRun)        {ePc, eIfid, eNoOp, eFlush, ePs} = 5'b00100;
      else if (frz)     {ePc, eIfid, eNoOp, eFlush, ePs} = 5'b00001;
      else if (lu)      {ePc, eIfid, eNoOp, eFlush, ePs} = 5'b00100;
      else if (brTaken) {ePc, eIfid, eNoOp, eFlush, ePs} = 5'b11010;
      else              {ePc, eIfid, eNoOp, eFlush, ePs} = 5'b11000;
   endtask

   // Advance the model across one rising edge.
   task automatic modelAdvance();
      if (mRun && !ePc) begin
         if (mStallA < MAXA) mStallA++;
         if (mStallB < MAXB) mStallB++;
      end
      if (eFlush) begin
         if (mFlushA < MAXA) mFlushA++;
         if (mFlushB < MAXB) mFlushB++;
      end
      if (!mRun) mRun = start;
      else if (eTrig) mOcc = LAT - 1;
      else if (mOcc > 0) mOcc--;
   endtask

   task automatic modelReset();
      mRun = 0; mOcc = 0;
      mStallA = 0; mStallB = 0; mFlushA = 0; mFlushB = 0;
   endtask

   task automatic applyStimulus(input bit st, input logic [6:0] op, input logic [4:0] rs1,
                                input logic [4:0] rs2, input bit mr, input logic [4:0] rd,
                                input bit br, input bit acc);
      start = st; idOp = op; idRs1 = rs1; idRs2 = rs2;
      exMemRead = mr; exRd = rd; brTaken = br; memAccess = acc;
      #1;
      modelEval();
   endtask

   task automatic clockCycle();
      @(posedge clk);
      modelAdvance();
      @(negedge clk);
      #1;
      modelEval();
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      modelReset();
      applyStimulus(0, OP_I, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({pcA, ifidA, noopA, flushA, psA, stateA} !== 7'b0010000) begin
         errors++; $display("[TB] FAIL reset_outputs: got %b expected 0010000", {pcA, ifidA, noopA, flushA, psA, stateA});
      end
      checks++;
      if (stallCntA !== '0 || flushCntA !== '0) begin
         errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stallCntA, flushCntA);
      end
      checks++;
      if (stateB !== 2'd0 || stallCntB !== '0) begin
         errors++; $display("[TB] FAIL reset_dutB: got state %0d stall %0d expected 0 0", stateB, stallCntB);
      end
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1, OP_I, 0, 0, 0, 0, 0, 0);
      clockCycle();
      applyStimulus(0, OP_I, 0, 0, 0, 0, 0, 0);
      checks++;
      if (stateA !== 2'd1 || pcA !== 1'b1) begin
         errors++; $display("[TB] FAIL start_run: got state %0d pc %0d expected 1 1", stateA, pcA);
      end
   endtask

   task automatic test_load_use();
      applyStimulus(0, OP_R, 1, 5, 1, 5, 0, 0);
      checks++;
      if (pcA !== 1'b0 || noopA !== 1'b1) begin
         errors++; $display("[TB] FAIL load_use_bubble: got pc %0d noop %0d expected 0 1", pcA, noopA);
      end
      clockCycle();
      applyStimulus(0, OP_R, 1, 5, 0, 0, 0, 0);
      checks++;
      if (stallCntA !== 16'(mStallA) || mStallA != 1) begin
         errors++; $display("[TB] FAIL load_use_count: got %0d expected 1 (model %0d)", stallCntA, mStallA);
      end
      checks++;
      if (pcA !== 1'b1) begin
         errors++; $display("[TB] FAIL load_use_single: got pc %0d expected 1", pcA);
      end
      applyStimulus(0, OP_R, 0, 0, 1, 0, 0, 0);
      checks++;
      if (pcA !== 1'b1 || noopA !== 1'b0) begin
         errors++; $display("[TB] FAIL load_use_x0: got pc %0d noop %0d expected 1 0", pcA, noopA);
      end
      applyStimulus(0, OP_I, 1, 5, 1, 5, 0, 0);
      checks++;
      if (pcA !== 1'b1 || noopA !== 1'b0) begin
         errors++; $display("[TB] FAIL load_use_itype: got pc %0d noop %0d expected 1 0", pcA, noopA);
      end
      clockCycle();
   endtask

   task automatic test_branch();
      applyStimulus(0, OP_B, 1, 2, 0, 0, 1, 0);
      checks++;
      if (flushA !== 1'b1 || pcA !== 1'b1) begin
         errors++; $display("[TB] FAIL branch_flush: got flush %0d pc %0d expected 1 1", flushA, pcA);
      end
      clockCycle();
      applyStimulus(0, OP_B, 5, 2, 1, 5, 1, 0);
      checks++;
      if (flushCntA !== 16'd1 || flushCntB !== 3'd1) begin
         errors++; $display("[TB] FAIL branch_count: got %0d/%0d expected 1/1", flushCntA, flushCntB);
      end
      checks++;
      if (flushA !== 1'b0 || noopA !== 1'b1) begin
         errors++; $display("[TB] FAIL branch_vs_load_use: got flush %0d noop %0d expected 0 1", flushA, noopA);
      end
      clockCycle();
   endtask

   task automatic test_mem_freeze();
      int expSt[5] = '{1, 2, 2, 2, 1};
      bit expPs[5] = '{1, 1, 1, 0, 0};
      int frozen = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, OP_I, 0, 0, 0, 0, 0, (i == 0));
         checks++;
         if (stateA !== 2'(expSt[i]) || psA !== expPs[i]) begin
            errors++; $display("[TB] FAIL mem_freeze_c%0d: got state %0d stall %0d expected %0d %0d",
                               i, stateA, psA, expSt[i], expPs[i]);
         end
         clockCycle();
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, OP_I, 0, 0, 0, 0, 0, 1);
         if (psA === 1'b1) frozen++;
         clockCycle();
      end
      applyStimulus(0, OP_I, 0, 0, 0, 0, 0, 0);
      checks++;
      if (frozen != 6 || stateA !== 2'd1) begin
         errors++; $display("[TB] FAIL mem_back_to_back: got %0d frozen state %0d expected 6 1", frozen, stateA);
      end
      clockCycle();
   endtask

   task automatic test_overlap();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, OP_R, 5, 6, 1, 5, 1, (i == 0));
         if (i < 3) begin
            checks++;
            if (noopA !== 1'b0 || flushA !== 1'b0 || psA !== 1'b1) begin
               errors++; $display("[TB] FAIL overlap_frozen_c%0d: got noop %0d flush %0d stall %0d expected 0 0 1",
                                  i, noopA, flushA, psA);
            end
         end else begin
            checks++;
            if (noopA !== 1'b1 || pcA !== 1'b0 || flushA !== 1'b0 || psA !== 1'b0) begin
               errors++; $display("[TB] FAIL overlap_release: got noop %0d pc %0d flush %0d stall %0d expected 1 0 0 0",
                                  noopA, pcA, flushA, psA);
            end
         end
         clockCycle();
      end
   endtask

   task automatic test_reset_memwait();
      applyStimulus(0, OP_I, 0, 0, 0, 0, 0, 1);
      clockCycle();
      applyStimulus(0, OP_I, 0, 0, 0, 0, 0, 0);
      checks++;
      if (stateA !== 2'd2) begin
         errors++; $display("[TB] FAIL memwait_entry: got state %0d expected 2", stateA);
      end
      #2;
      rstN = 1'b0;
      modelReset();
      #1;
      checks++;
      if (stateA !== 2'd0 || stallCntA !== '0 || flushCntA !== '0) begin
         errors++; $display("[TB] FAIL async_reset: got state %0d cnt %0d/%0d expected 0 0/0",
                            stateA, stallCntA, flushCntA);
      end
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1, OP_I, 0, 0, 0, 0, 0, 0);
      clockCycle();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, OP_R, 7, 7, 1, 7, 0, 0);
         clockCycle();
      end
      applyStimulus(0, OP_I, 0, 0, 0, 0, 0, 0);
      checks++;
      if (stallCntB !== 3'd7) begin
         errors++; $display("[TB] FAIL saturate_narrow: got %0d expected 7", stallCntB);
      end
      checks++;
      if (stallCntA !== 16'd10) begin
         errors++; $display("[TB] FAIL saturate_wide: got %0d expected 10", stallCntA);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops[5] = '{OP_R, OP_S, OP_L, OP_B, OP_I};
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 3) == 0), ops[$urandom_range(0, 4)],
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
         checks++;
         if ({pcA, ifidA, noopA, flushA, psA, stateA} !== {ePc, eIfid, eNoOp, eFlush, ePs, 2'(eState)}) begin
            errors++; $display("[TB] FAIL random_outA c%0d: got %b expected %b", i,
                               {pcA, ifidA, noopA, flushA, psA, stateA}, {ePc, eIfid, eNoOp, eFlush, ePs, 2'(eState)});
         end
         checks++;
         if ({pcB, ifidB, noopB, flushB, psB, stateB} !== {ePc, eIfid, eNoOp, eFlush, ePs, 2'(eState)}) begin
            errors++; $display("[TB] FAIL random_outB c%0d: got %b expected %b", i,
                               {pcB, ifidB, noopB, flushB, psB, stateB}, {ePc, eIfid, eNoOp, eFlush, ePs, 2'(eState)});
         end
         checks++;
         if (stallCntA !== 16'(mStallA) || flushCntA !== 16'(mFlushA)) begin
            errors++; $display("[TB] FAIL random_cntA c%0d: got %0d/%0d expected %0d/%0d", i,
                               stallCntA, flushCntA, mStallA, mFlushA);
         end
         checks++;
         if (stallCntB !== 3'(mStallB) || flushCntB !== 3'(mFlushB)) begin
            errors++; $display("[TB] FAIL random_cntB c%0d: got %0d/%0d expected %0d/%0d", i,
                               stallCntB, flushCntB, mStallB, mFlushB);
         end
         clockCycle();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_freeze();
      test_overlap();
      test_reset_memwait();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
